// File: rtl/rc4_mem_pkg.sv
// Shared types and RC4 S-box defaults for the S-memory init and key-scheduling blocks.
package rc4_mem_pkg;

  localparam int RC4_DATA_WIDTH = 8;
  localparam int RC4_DEPTH      = 256;

  typedef enum logic [1:0] {
    MODE_INDEX   = 2'b00,
    MODE_CONST   = 2'b01,
    MODE_DESCEND = 2'b10
  } init_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } init_state_t;

endpackage

// File: rtl/s_mem_pattern_gen.sv
// Combinational fill pattern for S-memory word `index`; mode 11 falls back to INDEX.
module s_mem_pattern_gen
  import rc4_mem_pkg::*;
#(
  parameter int DATA_WIDTH = RC4_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [ADDR_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0] pattern
);

  // Zero-extend then truncate so any ADDR_WIDTH/DATA_WIDTH ratio works.
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] index_wide;
  logic [DATA_WIDTH-1:0]            index_dw;
  logic                             unused_index_hi;

  assign index_wide      = {{DATA_WIDTH{1'b0}}, index};
  assign index_dw        = index_wide[DATA_WIDTH-1:0];
  assign unused_index_hi = ^index_wide[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    case (mode)
      MODE_CONST:   pattern = seed;
      MODE_DESCEND: pattern = seed - index_dw;
      default:      pattern = seed + index_dw;
    endcase
  end

endmodule

// File: rtl/s_mem_init_seq.sv
// S-memory init sequencer: sweeps every address with a fill pattern, then optionally
// reads it back and reports the first mismatching address.
//
// state     | meaning
// ST_IDLE   | waiting for start after reset
// ST_WRITE  | writing pattern(i) to address i, i = 0..DEPTH-1
// ST_VERIFY | presenting read address i, i = 0..DEPTH-1
// ST_DRAIN  | one cycle so the final read-back compare completes
// ST_DONE   | sweep finished, done_out held until the next start
module s_mem_init_seq
  import rc4_mem_pkg::*;
#(
  parameter int DATA_WIDTH = RC4_DATA_WIDTH,
  parameter int DEPTH      = RC4_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  verify_en,
  input  logic [DATA_WIDTH-1:0] q_in,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  write_enable_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  mismatch_out,
  output logic [ADDR_WIDTH-1:0] mismatch_addr_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  init_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic                  verify_q, verify_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mismatch_q, mismatch_d;
  logic [ADDR_WIDTH-1:0] mm_addr_q, mm_addr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  cmp_vld_q, cmp_vld_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;

  logic                  accept;
  logic                  last_idx;
  logic [DATA_WIDTH-1:0] wr_pattern;
  logic [DATA_WIDTH-1:0] exp_pattern;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_idx = (idx_q == LAST_IDX);

  s_mem_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_pattern (
    .mode    (mode_q),
    .seed    (seed_q),
    .index   (idx_q),
    .pattern (wr_pattern)
  );

  // Expected value follows the read address through the RAM's one-cycle latency.
  s_mem_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_exp_pattern (
    .mode    (mode_q),
    .seed    (seed_q),
    .index   (cmp_addr_q),
    .pattern (exp_pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      mode_q     <= MODE_INDEX;
      seed_q     <= '0;
      verify_q   <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      mm_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      verify_q   <= verify_d;
      address_q  <= address_d;
      data_q     <= data_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      mm_addr_q  <= mm_addr_d;
      rd_vld_q   <= rd_vld_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = accept ? mode      : mode_q;
    seed_d   = accept ? seed      : seed_q;
    verify_d = accept ? verify_en : verify_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = verify_q ? ST_VERIFY : ST_DONE;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      ST_VERIFY: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    address_d  = ((state_q == ST_WRITE) || (state_q == ST_VERIFY)) ? idx_q : address_q;
    data_d     = (state_q == ST_WRITE) ? wr_pattern : data_q;
    we_d       = (state_q == ST_WRITE);
    busy_d     = accept || (state_q == ST_WRITE) || (state_q == ST_VERIFY)
                 || (state_q == ST_DRAIN);
    done_d     = (state_q == ST_DONE) && !accept;
    rd_vld_d   = (state_q == ST_VERIFY);
    cmp_vld_d  = rd_vld_q;
    cmp_addr_d = address_q;
    mismatch_d = mismatch_q;
    mm_addr_d  = mm_addr_q;
    if (accept) begin
      mismatch_d = 1'b0;
      mm_addr_d  = '0;
    end else if (cmp_vld_q && (q_in != exp_pattern)) begin
      mismatch_d = 1'b1;
      if (!mismatch_q) mm_addr_d = cmp_addr_q;
    end
  end

  assign address_out       = address_q;
  assign data_out          = data_q;
  assign write_enable_out  = we_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign mismatch_out      = mismatch_q;
  assign mismatch_addr_out = mm_addr_q;

endmodule

// File: tb/tb_s_mem_init_seq.sv
// Directed bench for s_mem_init_seq: default 256-word instance plus a 200-word instance.
module tb_s_mem_init_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: default parameters ----------------
  logic       start_a, ver_a;
  logic [1:0] mode_a;
  logic [7:0] seed_a, q_a;
  logic [7:0] addr_a, data_a, mm_addr_a;
  logic       we_a, busy_a, done_a, mm_a;

  s_mem_init_seq dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start_a),
    .mode              (mode_a),
    .seed              (seed_a),
    .verify_en         (ver_a),
    .q_in              (q_a),
    .address_out       (addr_a),
    .data_out          (data_a),
    .write_enable_out  (we_a),
    .busy_out          (busy_a),
    .done_out          (done_a),
    .mismatch_out      (mm_a),
    .mismatch_addr_out (mm_addr_a)
  );

  // ---------------- DUT B: DEPTH = 200 ----------------
  logic       start_b;
  logic [1:0] mode_b;
  logic [7:0] seed_b;
  logic [7:0] addr_b, data_b, mm_addr_b;
  logic       we_b, busy_b, done_b, mm_b;

  s_mem_init_seq #(.DATA_WIDTH(8), .DEPTH(200)) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start_b),
    .mode              (mode_b),
    .seed              (seed_b),
    .verify_en         (1'b0),
    .q_in              (8'h00),
    .address_out       (addr_b),
    .data_out          (data_b),
    .write_enable_out  (we_b),
    .busy_out          (busy_b),
    .done_out          (done_b),
    .mismatch_out      (mm_b),
    .mismatch_addr_out (mm_addr_b)
  );

  // RAM model for A: synchronous write, registered read, optional corruption of words 7 and 30
  logic [7:0] mem_a [0:255];
  logic       corrupt;
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= data_a;
    q_a <= mem_a[addr_a] ^ ((corrupt && (addr_a == 8'd7 || addr_a == 8'd30)) ? 8'hFF : 8'h00);
  end

  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] s, input int i);
    logic [7:0] iv;
    iv = 8'(i);
    case (m)
      2'b01:   return s;
      2'b10:   return s - iv;
      default: return s + iv;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected {address, data} writes for A
  logic [15:0] sb_q[$];
  int          wr_cnt_a;
  always @(negedge clk) begin
    if (rst_n && we_a) begin
      wr_cnt_a++;
      chk("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk("write_addr_data", {16'h0, addr_a, data_a}, {16'h0, sb_q.pop_front()});
    end
  end

  // Write capture for B
  logic [7:0] mem_b [0:199];
  int         wr_cnt_b, bad_b;
  always @(negedge clk) begin
    if (rst_n && we_b) begin
      wr_cnt_b++;
      if (addr_b >= 8'd200) bad_b++;
      else mem_b[addr_b] = data_b;
    end
  end

  task automatic push_a(input logic [1:0] m, input logic [7:0] s);
    wr_cnt_a = 0;
    for (int i = 0; i < 256; i++) sb_q.push_back({8'(i), pat(m, s, i)});
  endtask

  // Leaves the caller just after the accepting edge
  task automatic do_start_a(input logic [1:0] m, input logic [7:0] s, input logic v);
    @(negedge clk);
    mode_a  = m;
    seed_a  = s;
    ver_a   = v;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int exp_lat, input bit inject, input string tag);
    int k;
    k = 0;
    chk({tag, "_busy_at_accept"}, 32'(busy_a), 32'd1);
    chk({tag, "_we_at_accept"}, 32'(we_a), 32'd0);
    while (!done_a && k < 2000) begin
      @(negedge clk);
      k++;
      start_a = inject && (k == 5 || k == 100);
    end
    start_a = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_write_count"}, 32'(wr_cnt_a), 32'd256);
    chk({tag, "_busy_done"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start_a = 1'b0; ver_a = 1'b0; mode_a = 2'b00; seed_a = 8'h00;
    start_b = 1'b0; mode_b = 2'b00; seed_b = 8'h00; corrupt = 1'b0;
    wr_cnt_a = 0; wr_cnt_b = 0; bad_b = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_mismatch", 32'(mm_a), 0);
    chk("rst_mm_addr", 32'(mm_addr_a), 0);
    rst_n = 1'b1;

    // INDEX, seed 0, no verify
    push_a(2'b00, 8'h00);
    do_start_a(2'b00, 8'h00, 1'b0);
    wait_done_a(257, 1'b0, "t1");
    chk("t1_mem255", 32'(mem_a[255]), 32'hFF);
    @(negedge clk);
    chk("t1_we_after", 32'(we_a), 0);
    chk("t1_done_held", 32'(done_a), 1);

    // DEPTH=200, DESCEND seed 0x10
    @(negedge clk);
    mode_b = 2'b10; seed_b = 8'h10; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t2_latency", 32'(k), 32'd201);
    chk("t2_mem0", 32'(mem_b[0]), 32'h10);
    chk("t2_mem17", 32'(mem_b[17]), 32'hFF);
    chk("t2_mem199", 32'(mem_b[199]), 32'h49);
    chk("t2_write_count", 32'(wr_cnt_b), 32'd200);
    chk("t2_out_of_range", 32'(bad_b), 0);

    // CONST 0xA5 with verify; input changes after acceptance must not matter
    push_a(2'b01, 8'hA5);
    do_start_a(2'b01, 8'hA5, 1'b1);
    mode_a = 2'b10; seed_a = 8'h33; ver_a = 1'b0;
    wait_done_a(514, 1'b0, "t3");
    chk("t3_mismatch", 32'(mm_a), 0);
    chk("t3_mem123", 32'(mem_a[123]), 32'hA5);

    // verify with corrupted words 7 and 30
    corrupt = 1'b1;
    push_a(2'b00, 8'h3C);
    do_start_a(2'b00, 8'h3C, 1'b1);
    wait_done_a(514, 1'b0, "t4");
    chk("t4_mismatch", 32'(mm_a), 1);
    chk("t4_mm_addr", 32'(mm_addr_a), 7);
    corrupt = 1'b0;

    // restart from DONE clears flags; starts during the sweep are ignored
    push_a(2'b10, 8'h80);
    do_start_a(2'b10, 8'h80, 1'b0);
    chk("t5_done_cleared", 32'(done_a), 0);
    chk("t5_mismatch_cleared", 32'(mm_a), 0);
    chk("t5_mm_addr_cleared", 32'(mm_addr_a), 0);
    wait_done_a(257, 1'b1, "t5");

    // asynchronous reset at write address 50
    push_a(2'b00, 8'h11);
    do_start_a(2'b00, 8'h11, 1'b0);
    k = 0;
    while (!(we_a && addr_a == 8'd50) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_addr50", 32'(we_a && addr_a == 8'd50), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(we_a), 0);
    chk("t6_rst_addr", 32'(addr_a), 0);
    chk("t6_rst_data", 32'(data_a), 0);
    chk("t6_rst_busy", 32'(busy_a), 0);
    chk("t6_rst_done", 32'(done_a), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    chk("t6_no_write_in_rst", 32'(we_a), 0);
    rst_n = 1'b1;
    push_a(2'b00, 8'h22);
    do_start_a(2'b00, 8'h22, 1'b0);
    wait_done_a(257, 1'b0, "t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
